// File: rtl/alu_rstation_bank.sv
// Multi-entry ALU reservation station: dispatch into free slots, CDB operand wakeup with
// same-cycle bypass, oldest-ready select with a sticky selection under issue back-pressure.
module alu_rstation_bank #(
  parameter int WIDTH     = 32,
  parameter int ROB       = 3,
  parameter int C_WIDTH   = 4,
  parameter int DEPTH     = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          globalReset_n,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic                          disp_rdy1,
  input  logic                          disp_rdy2,
  input  logic [WIDTH-1:0]              disp_val1,
  input  logic [WIDTH-1:0]              disp_val2,
  input  logic [ROB-1:0]                disp_rob1,
  input  logic [ROB-1:0]                disp_rob2,
  input  logic [ROB-1:0]                disp_robInstr,
  input  logic [C_WIDTH-1:0]            disp_ctrl,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB-1:0]      cdb_rob,
  input  logic [CDB_PORTS*WIDTH-1:0]    cdb_result,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [ROB-1:0]                issue_rob,
  output logic [C_WIDTH-1:0]            issue_ctrl,
  output logic [WIDTH-1:0]              issue_src1,
  output logic [WIDTH-1:0]              issue_src2,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  typedef struct packed {
    logic             hit;
    logic [WIDTH-1:0] val;
  } snoop_t;

  // Lowest-numbered matching CDB port wins, so scan from the top and let lower ports overwrite.
  function automatic snoop_t snoop(input logic [ROB-1:0]             tag,
                                   input logic [CDB_PORTS-1:0]       vld,
                                   input logic [CDB_PORTS*ROB-1:0]   rob,
                                   input logic [CDB_PORTS*WIDTH-1:0] res);
    snoop_t s;
    s = '0;
    for (int p = CDB_PORTS-1; p >= 0; p--) begin
      if (vld[p] && (rob[p*ROB +: ROB] == tag)) begin
        s.hit = 1'b1;
        s.val = res[p*WIDTH +: WIDTH];
      end
    end
    return s;
  endfunction

  // Entry state
  logic [DEPTH-1:0]   r_busy;
  logic [DEPTH-1:0]   r_lock_oh;
  logic [DEPTH-1:0]   r_rdy1;
  logic [DEPTH-1:0]   r_rdy2;
  logic [DEPTH-1:0]   r_older [DEPTH];   // r_older[i][j]: entry i was dispatched before entry j
  logic [ROB-1:0]     r_rob   [DEPTH];
  logic [ROB-1:0]     r_tag1  [DEPTH];
  logic [ROB-1:0]     r_tag2  [DEPTH];
  logic [C_WIDTH-1:0] r_ctrl  [DEPTH];
  logic [WIDTH-1:0]   r_val1  [DEPTH];
  logic [WIDTH-1:0]   r_val2  [DEPTH];

  snoop_t             w_snp1 [DEPTH];
  snoop_t             w_snp2 [DEPTH];
  snoop_t             w_dsnp1;
  snoop_t             w_dsnp2;
  logic [WIDTH-1:0]   w_op1  [DEPTH];
  logic [WIDTH-1:0]   w_op2  [DEPTH];
  logic [DEPTH-1:0]   w_elig;
  logic [DEPTH-1:0]   w_oldest_oh;
  logic [DEPTH-1:0]   w_sel_oh;
  logic [DEPTH-1:0]   w_free_oh;
  logic [DEPTH-1:0]   w_disp_oh;
  logic [DEPTH-1:0]   w_fire_oh;
  logic               w_disp;
  logic               w_fire;
  logic [ROB-1:0]     w_rob_mux;
  logic [C_WIDTH-1:0] w_ctrl_mux;
  logic [WIDTH-1:0]   w_src1_mux;
  logic [WIDTH-1:0]   w_src2_mux;

  // Wakeup snoop per stored operand; an operand is usable now if stored-ready or hit this cycle.
  always_comb begin
    w_dsnp1 = snoop(disp_rob1, cdb_valid, cdb_rob, cdb_result);
    w_dsnp2 = snoop(disp_rob2, cdb_valid, cdb_rob, cdb_result);
    for (int i = 0; i < DEPTH; i++) begin
      w_snp1[i] = snoop(r_tag1[i], cdb_valid, cdb_rob, cdb_result);
      w_snp2[i] = snoop(r_tag2[i], cdb_valid, cdb_rob, cdb_result);
      w_op1[i]  = r_rdy1[i] ? r_val1[i] : w_snp1[i].val;
      w_op2[i]  = r_rdy2[i] ? r_val2[i] : w_snp2[i].val;
      w_elig[i] = r_busy[i] && (r_rdy1[i] || w_snp1[i].hit) && (r_rdy2[i] || w_snp2[i].hit);
    end
  end

  // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    w_oldest_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_oldest_oh[i] = w_elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && w_elig[j] && r_older[j][i]) w_oldest_oh[i] = 1'b0;
      end
    end
  end

  assign w_sel_oh    = (|r_lock_oh) ? r_lock_oh : w_oldest_oh;
  assign issue_valid = |w_elig;
  assign w_fire      = issue_valid && issue_ready;
  assign w_fire_oh   = w_fire ? w_sel_oh : '0;

  // Isolate the lowest clear bit of r_busy: the lowest-index idle entry.
  assign w_free_oh   = ~r_busy & (r_busy + DEPTH'(1));
  assign disp_ready  = ~(&r_busy);
  assign w_disp      = disp_valid && disp_ready && !flush;
  assign w_disp_oh   = w_disp ? w_free_oh : '0;
  assign occupancy   = OW'($countones(r_busy));

  always_comb begin
    w_rob_mux  = '0;
    w_ctrl_mux = '0;
    w_src1_mux = '0;
    w_src2_mux = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel_oh[i]) begin
        w_rob_mux  = w_rob_mux  | r_rob[i];
        w_ctrl_mux = w_ctrl_mux | r_ctrl[i];
        w_src1_mux = w_src1_mux | w_op1[i];
        w_src2_mux = w_src2_mux | w_op2[i];
      end
    end
  end

  // With nothing selected the mux yields zeros; control idles at the all-ones NOP encoding.
  assign issue_rob  = w_rob_mux;
  assign issue_src1 = w_src1_mux;
  assign issue_src2 = w_src2_mux;
  assign issue_ctrl = issue_valid ? w_ctrl_mux : '1;

  // NOTE: sequential state is written with non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge globalReset_n) begin
    if (!globalReset_n) begin
      r_busy    <= '0;
      r_lock_oh <= '0;
    end else begin
      r_busy    <= flush ? '0 : ((r_busy & ~w_fire_oh) | w_disp_oh);
      r_lock_oh <= (!flush && issue_valid && !issue_ready) ? w_sel_oh : '0;
    end
  end

  // NOTE: payload and age storage are not reset; r_busy qualifies every read of them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_disp_oh[i]) begin
        r_rob[i]  <= disp_robInstr;
        r_ctrl[i] <= disp_ctrl;
        r_tag1[i] <= disp_rob1;
        r_tag2[i] <= disp_rob2;
        r_rdy1[i] <= disp_rdy1 || w_dsnp1.hit;
        r_rdy2[i] <= disp_rdy2 || w_dsnp2.hit;
        r_val1[i] <= disp_rdy1 ? disp_val1 : w_dsnp1.val;
        r_val2[i] <= disp_rdy2 ? disp_val2 : w_dsnp2.val;
      end else if (r_busy[i]) begin
        if (!r_rdy1[i] && w_snp1[i].hit) begin
          r_rdy1[i] <= 1'b1;
          r_val1[i] <= w_snp1[i].val;
        end
        if (!r_rdy2[i] && w_snp2[i].hit) begin
          r_rdy2[i] <= 1'b1;
          r_val2[i] <= w_snp2[i].val;
        end
      end
      // A newly written entry is younger than every entry currently busy.
      for (int j = 0; j < DEPTH; j++) begin
        if (w_disp_oh[j])      r_older[i][j] <= r_busy[i];
        else if (w_disp_oh[i]) r_older[i][j] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_rstation_bank.sv
// Self-checking bench for alu_rstation_bank: directed scenarios then random traffic, all
// compared against an age-ordered queue model of the reservation station.
module tb_alu_rstation_bank;

  localparam int WIDTH     = 32;
  localparam int ROB       = 3;
  localparam int C_WIDTH   = 4;
  localparam int DEPTH     = 4;
  localparam int CDB_PORTS = 2;

  logic                       clk = 1'b0;
  logic                       globalReset_n;
  logic                       flush;
  logic                       disp_valid;
  logic                       disp_ready;
  logic                       disp_rdy1, disp_rdy2;
  logic [WIDTH-1:0]           disp_val1, disp_val2;
  logic [ROB-1:0]             disp_rob1, disp_rob2, disp_robInstr;
  logic [C_WIDTH-1:0]         disp_ctrl;
  logic [CDB_PORTS-1:0]       cdb_valid;
  logic [CDB_PORTS*ROB-1:0]   cdb_rob;
  logic [CDB_PORTS*WIDTH-1:0] cdb_result;
  logic                       issue_valid;
  logic                       issue_ready;
  logic [ROB-1:0]             issue_rob;
  logic [C_WIDTH-1:0]         issue_ctrl;
  logic [WIDTH-1:0]           issue_src1, issue_src2;
  logic [2:0]                 occupancy;

  always #5 clk = ~clk;

  alu_rstation_bank #(
    .WIDTH(WIDTH), .ROB(ROB), .C_WIDTH(C_WIDTH), .DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS)
  ) dut (
    .clk(clk), .globalReset_n(globalReset_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .disp_val1(disp_val1), .disp_val2(disp_val2),
    .disp_rob1(disp_rob1), .disp_rob2(disp_rob2), .disp_robInstr(disp_robInstr),
    .disp_ctrl(disp_ctrl),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_result(cdb_result),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rob(issue_rob), .issue_ctrl(issue_ctrl),
    .issue_src1(issue_src1), .issue_src2(issue_src2),
    .occupancy(occupancy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: ops kept in dispatch order, front = oldest.
  typedef struct {
    logic [2:0]  rob;
    logic [3:0]  ctrl;
    bit          r1, r2;
    logic [31:0] v1, v2;
    logic [2:0]  t1, t2;
  } op_t;

  op_t        q[$];
  bit         m_locked;
  logic [2:0] m_lock_rob;
  int         m_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cdb_hit(input logic [2:0] tag, output logic [31:0] val);
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p] && (cdb_rob[p*ROB +: ROB] == tag)) begin
        val = cdb_result[p*WIDTH +: WIDTH];
        return 1'b1;
      end
    end
    val = '0;
    return 1'b0;
  endfunction

  function automatic bit ready_src(input bit r, input logic [31:0] v, input logic [2:0] t,
                                   output logic [31:0] src);
    if (r) begin
      src = v;
      return 1'b1;
    end
    return cdb_hit(t, src);
  endfunction

  function automatic logic [2:0] free_tag();
    int         s;
    logic [2:0] c;
    bit         used;
    s = int'($urandom_range(0, 7));
    for (int k = 0; k < 8; k++) begin
      c = 3'((s + k) % 8);
      used = 1'b0;
      foreach (q[i]) if (q[i].rob == c) used = 1'b1;
      if (!used) return c;
    end
    return 3'd0;
  endfunction

  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0; disp_rdy1 = 1'b0; disp_rdy2 = 1'b0;
    disp_val1 = '0; disp_val2 = '0; disp_rob1 = '0; disp_rob2 = '0;
    disp_robInstr = '0; disp_ctrl = '0;
    cdb_valid = '0; cdb_rob = '0; cdb_result = '0; issue_ready = 1'b0;
  endtask

  task automatic disp(input logic [2:0] rob, input logic [3:0] ctrl,
                      input bit r1, input logic [31:0] v1, input logic [2:0] t1,
                      input bit r2, input logic [31:0] v2, input logic [2:0] t2);
    disp_valid = 1'b1; disp_robInstr = rob; disp_ctrl = ctrl;
    disp_rdy1 = r1; disp_val1 = v1; disp_rob1 = t1;
    disp_rdy2 = r2; disp_val2 = v2; disp_rob2 = t2;
  endtask

  // Predict this cycle's outputs from the model and compare.
  task automatic observe(input string tag);
    logic [31:0] s1, s2;
    bit          ok1, ok2;
    #1;
    m_sel = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (m_sel < 0) begin
        ok1 = ready_src(q[i].r1, q[i].v1, q[i].t1, s1);
        ok2 = ready_src(q[i].r2, q[i].v2, q[i].t2, s2);
        if (m_locked ? (q[i].rob == m_lock_rob) : (ok1 && ok2)) m_sel = i;
      end
    end
    check($sformatf("%s.occupancy", tag), 32'(occupancy), 32'(q.size()));
    check($sformatf("%s.disp_ready", tag), 32'(disp_ready), 32'(q.size() < DEPTH));
    check($sformatf("%s.issue_valid", tag), 32'(issue_valid), 32'(m_sel >= 0));
    if (m_sel >= 0) begin
      void'(ready_src(q[m_sel].r1, q[m_sel].v1, q[m_sel].t1, s1));
      void'(ready_src(q[m_sel].r2, q[m_sel].v2, q[m_sel].t2, s2));
      check($sformatf("%s.issue_rob", tag), 32'(issue_rob), 32'(q[m_sel].rob));
      check($sformatf("%s.issue_ctrl", tag), 32'(issue_ctrl), 32'(q[m_sel].ctrl));
      check($sformatf("%s.issue_src1", tag), issue_src1, s1);
      check($sformatf("%s.issue_src2", tag), issue_src2, s2);
    end
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    bit          disp_ok, lock_next;
    logic [2:0]  lock_rob;
    logic [31:0] v;
    op_t         e;
    disp_ok   = disp_valid && (q.size() < DEPTH) && !flush;
    lock_next = !flush && (m_sel >= 0) && !issue_ready;
    lock_rob  = (m_sel >= 0) ? q[m_sel].rob : 3'd0;
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      if (!e.r1 && cdb_hit(e.t1, v)) begin e.r1 = 1'b1; e.v1 = v; end
      if (!e.r2 && cdb_hit(e.t2, v)) begin e.r2 = 1'b1; e.v2 = v; end
      q[i] = e;
    end
    if ((m_sel >= 0) && issue_ready) q.delete(m_sel);
    if (disp_ok) begin
      e.rob = disp_robInstr; e.ctrl = disp_ctrl;
      e.t1 = disp_rob1; e.t2 = disp_rob2;
      e.r1 = disp_rdy1 || cdb_hit(disp_rob1, v); e.v1 = disp_rdy1 ? disp_val1 : v;
      e.r2 = disp_rdy2 || cdb_hit(disp_rob2, v); e.v2 = disp_rdy2 ? disp_val2 : v;
      q.push_back(e);
    end
    if (flush) q.delete();
    m_locked   = lock_next;
    m_lock_rob = lock_rob;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    m_locked = 1'b0; m_lock_rob = '0; m_sel = -1;
    globalReset_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("reset.occupancy", 32'(occupancy), 32'd0);
    check("reset.issue_valid", 32'(issue_valid), 32'd0);
    check("reset.issue_ctrl", 32'(issue_ctrl), 32'hF);
    check("reset.disp_ready", 32'(disp_ready), 32'd1);
    @(negedge clk);
    globalReset_n = 1'b1;

    // Two ready ops drain oldest first.
    idle(); disp(3'd1, 4'h2, 1, 32'd10, 3'd0, 1, 32'd20, 3'd0); observe("t2.d1"); tick();
    idle(); disp(3'd2, 4'h3, 1, 32'd30, 3'd0, 1, 32'd40, 3'd0); observe("t2.d2"); tick();
    idle(); issue_ready = 1'b1; observe("t2.i1");
    check("t2.first_rob", 32'(issue_rob), 32'd1);
    check("t2.occ2", 32'(occupancy), 32'd2);
    tick();
    idle(); issue_ready = 1'b1; observe("t2.i2");
    check("t2.second_rob", 32'(issue_rob), 32'd2);
    check("t2.occ1", 32'(occupancy), 32'd1);
    tick();
    idle(); observe("t2.empty");
    check("t2.occ0", 32'(occupancy), 32'd0);
    tick();

    // Zero-cycle wakeup-to-issue through the CDB bypass on port 1.
    idle(); disp(3'd3, 4'h5, 0, 32'd0, 3'd5, 1, 32'd7, 3'd0); observe("t3.d"); tick();
    idle(); cdb_valid = 2'b10; cdb_rob = {3'd5, 3'd0}; cdb_result = {32'hDEAD_BEEF, 32'h0};
    issue_ready = 1'b1; observe("t3.wake");
    check("t3.bypass_valid", 32'(issue_valid), 32'd1);
    check("t3.bypass_src1", issue_src1, 32'hDEAD_BEEF);
    tick();
    idle(); observe("t3.after"); tick();

    // Fill, drop the extra dispatch, free one slot.
    for (int k = 0; k < DEPTH; k++) begin
      idle(); disp(3'(k), 4'(k), 0, 32'd0, 3'd6, 1, 32'(k), 3'd0); observe("t4.fill"); tick();
    end
    idle(); disp(3'd7, 4'h7, 1, 32'd1, 3'd0, 1, 32'd2, 3'd0); observe("t4.full");
    check("t4.full_not_ready", 32'(disp_ready), 32'd0);
    tick();
    idle(); cdb_valid = 2'b01; cdb_rob = {3'd0, 3'd6}; cdb_result = {32'h0, 32'h600};
    issue_ready = 1'b1; observe("t4.wake");
    check("t4.dropped_occ", 32'(occupancy), 32'd4);
    check("t4.oldest_rob", 32'(issue_rob), 32'd0);
    tick();
    idle(); observe("t4.freed");
    check("t4.ready_again", 32'(disp_ready), 32'd1);
    tick();
    for (int k = 1; k < DEPTH; k++) begin
      idle(); issue_ready = 1'b1; observe("t4.drain");
      check("t4.drain_rob", 32'(issue_rob), 32'(k));
      tick();
    end
    idle(); observe("t4.empty"); tick();

    // Locked young entry keeps priority over an older entry that wakes later.
    idle(); disp(3'd4, 4'h1, 0, 32'd0, 3'd6, 1, 32'd5, 3'd0); observe("t5.old"); tick();
    idle(); disp(3'd5, 4'h2, 1, 32'd50, 3'd0, 1, 32'd51, 3'd0); observe("t5.young"); tick();
    idle(); observe("t5.stall");
    check("t5.stall_rob", 32'(issue_rob), 32'd5);
    tick();
    idle(); cdb_valid = 2'b01; cdb_rob = {3'd0, 3'd6}; cdb_result = {32'h0, 32'h66};
    observe("t5.oldwake");
    check("t5.lock_holds", 32'(issue_rob), 32'd5);
    tick();
    idle(); issue_ready = 1'b1; observe("t5.accept_young");
    check("t5.young_src1", issue_src1, 32'd50);
    tick();
    idle(); issue_ready = 1'b1; observe("t5.accept_old");
    check("t5.old_rob", 32'(issue_rob), 32'd4);
    check("t5.old_src1", issue_src1, 32'h66);
    tick();
    idle(); observe("t5.empty"); tick();

    // Flush discards entries and same-cycle dispatch; dual-port hit takes port 0.
    for (int k = 1; k <= 3; k++) begin
      idle(); disp(3'(k), 4'h4, 0, 32'd0, 3'd7, 1, 32'd9, 3'd0); observe("t6.fill"); tick();
    end
    idle(); flush = 1'b1; disp(3'd4, 4'h4, 1, 32'd1, 3'd0, 1, 32'd1, 3'd0); observe("t6.flush");
    tick();
    idle(); observe("t6.post");
    check("t6.flushed_occ", 32'(occupancy), 32'd0);
    tick();
    idle(); disp(3'd6, 4'h9, 0, 32'd0, 3'd3, 1, 32'd8, 3'd0); observe("t6.d"); tick();
    idle(); cdb_valid = 2'b11; cdb_rob = {3'd3, 3'd3}; cdb_result = {32'h222, 32'h111};
    observe("t6.dual");
    check("t6.port0_wins", issue_src1, 32'h111);
    tick();
    idle(); cdb_valid = 2'b01; cdb_rob = {3'd0, 3'd3}; cdb_result = {32'h0, 32'h333};
    issue_ready = 1'b1; observe("t6.stable");
    check("t6.captured_src1", issue_src1, 32'h111);
    tick();
    idle(); observe("t6.empty"); tick();

    // Asynchronous reset with three entries busy.
    for (int k = 1; k <= 3; k++) begin
      idle(); disp(3'(k), 4'h3, 0, 32'd0, 3'd7, 1, 32'd9, 3'd0); observe("t1.fill"); tick();
    end
    idle();
    #2 globalReset_n = 1'b0;
    #1;
    check("t1.occupancy", 32'(occupancy), 32'd0);
    check("t1.issue_valid", 32'(issue_valid), 32'd0);
    check("t1.issue_ctrl", 32'(issue_ctrl), 32'hF);
    q.delete();
    m_locked = 1'b0;
    @(negedge clk);
    globalReset_n = 1'b1;
    observe("t1.released"); tick();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      idle();
      flush         = ($urandom_range(0, 24) == 0);
      disp_valid    = 1'($urandom_range(0, 1));
      disp_robInstr = free_tag();
      disp_ctrl     = 4'($urandom);
      disp_rdy1     = 1'($urandom_range(0, 1));
      disp_rdy2     = 1'($urandom_range(0, 1));
      disp_val1     = $urandom();
      disp_val2     = $urandom();
      disp_rob1     = 3'($urandom_range(0, 7));
      disp_rob2     = 3'($urandom_range(0, 7));
      cdb_valid     = 2'($urandom_range(0, 3));
      cdb_rob       = 6'($urandom);
      cdb_result    = {$urandom(), $urandom()};
      issue_ready   = ($urandom_range(0, 9) < 6);
      observe("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
